// File: rtl/pic_command_sequencer.sv
// pic_command_sequencer: bus-side command sequencer for an 8259A-compatible PIC.
// Captures CPU writes, commits each one when the write strobe drops, and runs the
// ICW1->ICW2->(ICW3)->(ICW4) initialisation sequence before accepting OCWs.
// Holds every programmed register, emits one-cycle OCW/ICW1 pulses and drives
// the IMR/IRR/ISR read mux.
module pic_command_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter bit SYNC_INPUTS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chip_select_bar,
    input  logic                  write_bar,
    input  logic                  read_bar,
    input  logic                  A0,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] irr_in,
    input  logic [DATA_WIDTH-1:0] isr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_enable,
    output logic                  init_done,
    output logic [4:0]            vector_base,
    output logic                  level_triggered,
    output logic                  single_mode,
    output logic                  icw4_needed,
    output logic [DATA_WIDTH-1:0] cascade_config,
    output logic                  micro_mode,
    output logic                  auto_eoi,
    output logic                  master_select,
    output logic                  buffered_mode,
    output logic                  special_fully_nested,
    output logic [DATA_WIDTH-1:0] interrupt_mask,
    output logic                  ocw2_pulse,
    output logic [2:0]            ocw2_command,
    output logic [2:0]            ocw2_level,
    output logic                  poll_pulse,
    output logic                  special_mask_mode,
    output logic                  read_isr_select,
    output logic                  icw1_pulse
);

    typedef enum logic [2:0] {
        WAIT_ICW1,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    // Conditioned write-side inputs. Strobes are carried active-high so that a
    // cleared synchronizer reads as "no write in progress".
    logic                  cs_act_s;
    logic                  wr_act_s;
    logic                  a0_s;
    logic [DATA_WIDTH-1:0] din_s;

    generate
        if (SYNC_INPUTS) begin : g_sync
            logic [1:0]                 cs_sync_q;
            logic [1:0]                 wr_sync_q;
            logic [1:0]                 a0_sync_q;
            logic [1:0][DATA_WIDTH-1:0] din_sync_q;

            // Two-flop synchronizer on every write-side pin
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cs_sync_q  <= '0;
                    wr_sync_q  <= '0;
                    a0_sync_q  <= '0;
                    din_sync_q <= '0;
                end else begin
                    cs_sync_q  <= {cs_sync_q[0], ~chip_select_bar};
                    wr_sync_q  <= {wr_sync_q[0], ~write_bar};
                    a0_sync_q  <= {a0_sync_q[0], A0};
                    din_sync_q <= {din_sync_q[0], data_in};
                end
            end

            assign cs_act_s = cs_sync_q[1];
            assign wr_act_s = wr_sync_q[1];
            assign a0_s     = a0_sync_q[1];
            assign din_s    = din_sync_q[1];
        end else begin : g_nosync
            assign cs_act_s = ~chip_select_bar;
            assign wr_act_s = ~write_bar;
            assign a0_s     = A0;
            assign din_s    = data_in;
        end
    endgenerate

    logic wr_active;
    assign wr_active = cs_act_s & wr_act_s;

    // Write capture: the last sampled word of a write is what gets committed
    logic                  wr_prev_q;
    logic                  hold_a0_q;
    logic [DATA_WIDTH-1:0] hold_data_q;

    // Holding registers follow the bus while the write is active
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_prev_q   <= 1'b0;
            hold_a0_q   <= 1'b0;
            hold_data_q <= '0;
        end else begin
            wr_prev_q <= wr_active;
            if (wr_active) begin
                hold_a0_q   <= a0_s;
                hold_data_q <= din_s;
            end
        end
    end

    // Commit on the first sampled-inactive edge after an active one
    logic commit;
    logic is_icw1;
    assign commit  = wr_prev_q & ~wr_active;
    assign is_icw1 = ~hold_a0_q & hold_data_q[4];

    state_t                state_q, state_d;
    logic [4:0]            vb_q, vb_d;
    logic                  lt_q, lt_d;
    logic                  sngl_q, sngl_d;
    logic                  ic4_q, ic4_d;
    logic [DATA_WIDTH-1:0] cas_q, cas_d;
    logic [4:0]            icw4_q, icw4_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [2:0]            lvl_q, lvl_d;
    logic                  smm_q, smm_d;
    logic                  ris_q, ris_d;
    logic                  icw1_p_q, icw1_p_d;
    logic                  ocw2_p_q, ocw2_p_d;
    logic                  poll_p_q, poll_p_d;

    // State and command register bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_ICW1;
            vb_q     <= '0;
            lt_q     <= 1'b0;
            sngl_q   <= 1'b0;
            ic4_q    <= 1'b0;
            cas_q    <= '0;
            icw4_q   <= '0;
            mask_q   <= '0;
            cmd_q    <= '0;
            lvl_q    <= '0;
            smm_q    <= 1'b0;
            ris_q    <= 1'b0;
            icw1_p_q <= 1'b0;
            ocw2_p_q <= 1'b0;
            poll_p_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vb_q     <= vb_d;
            lt_q     <= lt_d;
            sngl_q   <= sngl_d;
            ic4_q    <= ic4_d;
            cas_q    <= cas_d;
            icw4_q   <= icw4_d;
            mask_q   <= mask_d;
            cmd_q    <= cmd_d;
            lvl_q    <= lvl_d;
            smm_q    <= smm_d;
            ris_q    <= ris_d;
            icw1_p_q <= icw1_p_d;
            ocw2_p_q <= ocw2_p_d;
            poll_p_q <= poll_p_d;
        end
    end

    // Command decode: ICW1 restarts from any state, otherwise decode by state
    always_comb begin
        state_d  = state_q;
        vb_d     = vb_q;
        lt_d     = lt_q;
        sngl_d   = sngl_q;
        ic4_d    = ic4_q;
        cas_d    = cas_q;
        icw4_d   = icw4_q;
        mask_d   = mask_q;
        cmd_d    = cmd_q;
        lvl_d    = lvl_q;
        smm_d    = smm_q;
        ris_d    = ris_q;
        icw1_p_d = 1'b0;
        ocw2_p_d = 1'b0;
        poll_p_d = 1'b0;

        if (commit) begin
            if (is_icw1) begin
                ic4_d    = hold_data_q[0];
                sngl_d   = hold_data_q[1];
                lt_d     = hold_data_q[3];
                mask_d   = '0;
                smm_d    = 1'b0;
                ris_d    = 1'b0;
                icw4_d   = '0;
                icw1_p_d = 1'b1;
                state_d  = WAIT_ICW2;
            end else begin
                unique case (state_q)
                    WAIT_ICW2: if (hold_a0_q) begin
                        vb_d = hold_data_q[7:3];
                        if (!sngl_q)    state_d = WAIT_ICW3;
                        else if (ic4_q) state_d = WAIT_ICW4;
                        else            state_d = READY;
                    end
                    WAIT_ICW3: if (hold_a0_q) begin
                        cas_d   = hold_data_q;
                        state_d = ic4_q ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: if (hold_a0_q) begin
                        icw4_d  = hold_data_q[4:0];
                        state_d = READY;
                    end
                    READY: begin
                        if (hold_a0_q) begin
                            mask_d = hold_data_q;
                        end else if (!hold_data_q[3]) begin
                            cmd_d    = hold_data_q[7:5];
                            lvl_d    = hold_data_q[2:0];
                            ocw2_p_d = 1'b1;
                        end else begin
                            if (hold_data_q[1]) ris_d = hold_data_q[0];
                            if (hold_data_q[6]) smm_d = hold_data_q[5];
                            poll_p_d = hold_data_q[2];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read path works straight off the pins; a concurrent write suppresses it
    assign data_out_enable = ~chip_select_bar & ~read_bar & write_bar;

    // Status mux onto the read bus, zero when not driving
    always_comb begin
        data_out = '0;
        if (data_out_enable) begin
            if (A0)         data_out = mask_q;
            else if (ris_q) data_out = isr_in;
            else            data_out = irr_in;
        end
    end

    assign init_done            = (state_q == READY);
    assign vector_base          = vb_q;
    assign level_triggered      = lt_q;
    assign single_mode          = sngl_q;
    assign icw4_needed          = ic4_q;
    assign cascade_config       = cas_q;
    assign micro_mode           = icw4_q[0];
    assign auto_eoi             = icw4_q[1];
    assign master_select        = icw4_q[2];
    assign buffered_mode        = icw4_q[3];
    assign special_fully_nested = icw4_q[4];
    assign interrupt_mask       = mask_q;
    assign ocw2_pulse           = ocw2_p_q;
    assign ocw2_command         = cmd_q;
    assign ocw2_level           = lvl_q;
    assign poll_pulse           = poll_p_q;
    assign special_mask_mode    = smm_q;
    assign read_isr_select      = ris_q;
    assign icw1_pulse           = icw1_p_q;

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Bench for pic_command_sequencer: one unsynchronized and one synchronized
// instance share the same pins and are both checked against a queue-based
// model of the initialisation sequence and OCW decode.
module tb_pic_command_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n, wr_n, rd_n, a0;
    logic [7:0] din, irr, isr;

    wire [1:0][7:0] dout, casc, mask;
    wire [1:0][4:0] vb;
    wire [1:0][2:0] cmd, lvl;
    wire [1:0]      doe, idone, lt, sm, ic4, mm, aeoi, ms, bm, sfnm;
    wire [1:0]      o2p, pp, smm, ris, i1p;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pic_command_sequencer #(.DATA_WIDTH(8), .SYNC_INPUTS(g == 1)) u_dut (
            .clk(clk), .reset(rst),
            .chip_select_bar(cs_n), .write_bar(wr_n), .read_bar(rd_n),
            .A0(a0), .data_in(din), .irr_in(irr), .isr_in(isr),
            .data_out(dout[g]), .data_out_enable(doe[g]), .init_done(idone[g]),
            .vector_base(vb[g]), .level_triggered(lt[g]), .single_mode(sm[g]),
            .icw4_needed(ic4[g]), .cascade_config(casc[g]),
            .micro_mode(mm[g]), .auto_eoi(aeoi[g]), .master_select(ms[g]),
            .buffered_mode(bm[g]), .special_fully_nested(sfnm[g]),
            .interrupt_mask(mask[g]), .ocw2_pulse(o2p[g]),
            .ocw2_command(cmd[g]), .ocw2_level(lvl[g]), .poll_pulse(pp[g]),
            .special_mask_mode(smm[g]), .read_isr_select(ris[g]),
            .icw1_pulse(i1p[g])
        );
    end

    // Pulse monitors: count high cycles so a stretched pulse shows up as extra
    int cyc = 0;
    int c_o2[2] = '{0, 0};
    int c_pp[2] = '{0, 0};
    int c_i1[2] = '{0, 0};
    int last_o2[2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o2p[k]) begin
                c_o2[k]    <= c_o2[k] + 1;
                last_o2[k] <= cyc;
            end
            if (pp[k])  c_pp[k] <= c_pp[k] + 1;
            if (i1p[k]) c_i1[k] <= c_i1[k] + 1;
        end
    end

    // Reference model: pending ICW slots kept as a queue built at ICW1
    int         pend[$];
    bit         m_ready;
    logic [4:0] m_vb, m_icw4;
    logic       m_lt, m_sngl, m_ic4, m_smm, m_ris;
    logic [7:0] m_cas, m_mask;
    logic [2:0] m_cmd, m_lvl;
    int         e_o2 = 0, e_pp = 0, e_i1 = 0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic model_reset();
        pend.delete();
        m_ready = 0; m_vb = 0; m_icw4 = 0; m_lt = 0; m_sngl = 0; m_ic4 = 0;
        m_smm = 0; m_ris = 0; m_cas = 0; m_mask = 0; m_cmd = 0; m_lvl = 0;
    endtask

    task automatic model_write(input logic wa0, input logic [7:0] d);
        int slot;
        if (!wa0 && d[4]) begin
            m_lt = d[3]; m_sngl = d[1]; m_ic4 = d[0];
            m_mask = 0; m_smm = 0; m_ris = 0; m_icw4 = 0;
            pend.delete();
            pend.push_back(2);
            if (!m_sngl) pend.push_back(3);
            if (m_ic4)   pend.push_back(4);
            m_ready = 0;
            e_i1++;
        end else if (pend.size() > 0) begin
            if (wa0) begin
                slot = pend.pop_front();
                if (slot == 2) m_vb = d[7:3];
                if (slot == 3) m_cas = d;
                if (slot == 4) m_icw4 = d[4:0];
                if (pend.size() == 0) m_ready = 1;
            end
        end else if (m_ready) begin
            if (wa0) m_mask = d;
            else if (!d[3]) begin
                m_cmd = d[7:5]; m_lvl = d[2:0]; e_o2++;
            end else begin
                if (d[1]) m_ris = d[0];
                if (d[2]) e_pp++;
                if (d[6]) m_smm = d[5];
            end
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (t=%0t)", nm, k, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, ".init_done"}, k, idone[k], m_ready);
            chk({tag, ".vector_base"}, k, vb[k], m_vb);
            chk({tag, ".icw1_bits"}, k, {lt[k], sm[k], ic4[k]}, {m_lt, m_sngl, m_ic4});
            chk({tag, ".cascade"}, k, casc[k], m_cas);
            chk({tag, ".icw4"}, k, {sfnm[k], bm[k], ms[k], aeoi[k], mm[k]}, m_icw4);
            chk({tag, ".mask"}, k, mask[k], m_mask);
            chk({tag, ".ocw2"}, k, {cmd[k], lvl[k]}, {m_cmd, m_lvl});
            chk({tag, ".smm_ris"}, k, {smm[k], ris[k]}, {m_smm, m_ris});
            chk({tag, ".pulse_counts"}, k, {c_o2[k][7:0], c_pp[k][7:0], c_i1[k][7:0]},
                {e_o2[7:0], e_pp[7:0], e_i1[7:0]});
        end
    endtask

    task automatic do_write(input logic wa0, input logic [7:0] d, input int hold);
        @(negedge clk);
        cs_n = 0; wr_n = 0; a0 = wa0; din = d;
        repeat (hold) @(negedge clk);
        cs_n = 1; wr_n = 1;
        repeat (6) @(negedge clk);
        model_write(wa0, d);
    endtask

    task automatic rd_check(input logic ra0, input logic [7:0] ir, input logic [7:0] is);
        logic [7:0] exp;
        @(negedge clk);
        irr = ir; isr = is; a0 = ra0;
        cs_n = 0; rd_n = 0; wr_n = 1;
        #1;
        exp = ra0 ? m_mask : (m_ris ? is : ir);
        for (int k = 0; k < 2; k++) begin
            chk("read.enable", k, doe[k], 1);
            chk("read.data", k, dout[k], exp);
        end
        wr_n = 0;
        #1;
        for (int k = 0; k < 2; k++) chk("read_write.enable", k, {doe[k], dout[k]}, 0);
        wr_n = 1; cs_n = 1; rd_n = 1;
        #1;
        for (int k = 0; k < 2; k++) chk("idle.data", k, {doe[k], dout[k]}, 0);
    endtask

    typedef struct {
        logic       a0;
        logic [7:0] d;
        logic [7:0] e_mask;
        logic [4:0] e_vb;
        logic       e_done;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{0, 8'h13, 8'h00, 5'd0, 0},
            '{1, 8'h48, 8'h00, 5'd9, 0},
            '{1, 8'h03, 8'h00, 5'd9, 1},
            '{0, 8'h11, 8'h00, 5'd9, 0},
            '{1, 8'h20, 8'h00, 5'd4, 0},
            '{1, 8'h04, 8'h00, 5'd4, 0},
            '{1, 8'h1D, 8'h00, 5'd4, 1},
            '{1, 8'hA5, 8'hA5, 5'd4, 1},
            '{0, 8'h0B, 8'hA5, 5'd4, 1},
            '{0, 8'h63, 8'hA5, 5'd4, 1},
            '{0, 8'h6C, 8'hA5, 5'd4, 1},
            '{1, 8'hFF, 8'hFF, 5'd4, 1},
            '{0, 8'h11, 8'h00, 5'd4, 0},
            '{1, 8'h30, 8'h00, 5'd6, 0},
            '{0, 8'h11, 8'h00, 5'd6, 0},
            '{1, 8'h20, 8'h00, 5'd4, 0},
            '{1, 8'h07, 8'h00, 5'd4, 0},
            '{1, 8'h1D, 8'h00, 5'd4, 1}
        };

        rst = 1; cs_n = 1; wr_n = 1; rd_n = 1; a0 = 0; din = 0; irr = 0; isr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_model("reset");
        for (int k = 0; k < 2; k++) chk("reset.read", k, {doe[k], dout[k]}, 0);
        rst = 0;

        // Ignored writes before ICW1
        do_write(1, 8'h77, 1);
        do_write(0, 8'h0B, 1);
        check_model("pre_icw1");

        // Directed table
        for (int i = 0; i < 18; i++) begin
            do_write(vecs[i].a0, vecs[i].d, 1 + (i % 3));
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("vec%0d.mask", i), k, mask[k], vecs[i].e_mask);
                chk($sformatf("vec%0d.vb", i), k, vb[k], vecs[i].e_vb);
                chk($sformatf("vec%0d.done", i), k, idone[k], vecs[i].e_done);
                if (i == 2) chk("vec2.mm_aeoi", k, {mm[k], aeoi[k]}, 2'b11);
                if (i == 6) chk("vec6.icw4", k, {casc[k], sfnm[k], bm[k], ms[k], aeoi[k], mm[k]},
                                {8'h04, 5'b11101});
                if (i == 9) chk("vec9.ocw2", k, {cmd[k], lvl[k]}, {3'd3, 3'd3});
                if (i == 10) chk("vec10.smm", k, smm[k], 1);
                if (i == 16) chk("vec16.cascade", k, casc[k], 8'h07);
            end
            check_model($sformatf("vec%0d", i));
            if (i == 8) begin
                rd_check(1, 8'h12, 8'h80);
                rd_check(0, 8'h12, 8'h80);
                for (int k = 0; k < 2; k++) chk("vec8.read_isr", k, ris[k], 1);
            end
        end

        // Reset in the middle of a held write discards it
        do_write(1, 8'h5A, 1);
        @(negedge clk);
        cs_n = 0; wr_n = 0; a0 = 0; din = 8'h20;
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        for (int k = 0; k < 2; k++)
            chk("midreset.outputs", k, {mask[k], vb[k], idone[k], o2p[k], casc[k]}, 0);
        cs_n = 1; wr_n = 1;
        @(negedge clk);
        rst = 0;
        repeat (8) @(negedge clk);
        model_reset();
        check_model("after_midreset");

        // Long-held OCW2: single pulse, synchronized copy two clocks later
        do_write(0, 8'h13, 1);
        do_write(1, 8'h48, 1);
        do_write(1, 8'h03, 1);
        do_write(0, 8'hA4, 10);
        check_model("held_ocw2");
        chk("held_ocw2.sync_delay", 1, last_o2[1] - last_o2[0], 2);

        // Randomized traffic against the model
        for (int n = 0; n < 250; n++) begin
            logic       ra0;
            logic [7:0] rd;
            ra0 = 1'($urandom_range(0, 1));
            rd  = 8'($urandom);
            if (!ra0 && $urandom_range(0, 5) != 0) rd[4] = 1'b0;
            do_write(ra0, rd, $urandom_range(1, 4));
            check_model($sformatf("rnd%0d", n));
            rd_check(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
